// File: rtl/multicycle_subtractor.sv
// rtl/multicycle_subtractor.sv - chunk-serial WIDTH-bit subtractor D = A - B - Bin with valid/ready handshake
// Optional signed-overflow output ovf is built only when SUB_OVF_EN is defined.
module multicycle_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("multicycle_subtractor: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] diff;
  logic             brw_n;
  logic             last;

  // One extra bit on the chunk difference turns into the borrow for the next chunk.
  always_comb begin
    a_c           = a_q[int'(cnt)*CHUNK +: CHUNK];
    b_c           = b_q[int'(cnt)*CHUNK +: CHUNK];
    {brw_n, diff} = {1'b0, a_c} - {1'b0, b_c} - {{CHUNK{1'b0}}, borrow};
    last          = (cnt == CW'(NCHUNK - 1));
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      d         <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          d[int'(cnt)*CHUNK +: CHUNK] <= diff;
          borrow <= brw_n;
          cnt    <= cnt + CW'(1);
          if (last) begin
            bout      <= brw_n;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUB_OVF_EN
            // diff[CHUNK-1] is the result MSB on the final chunk.
            ovf <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_subtractor.sv
// tb/tb_multicycle_subtractor.sv - directed and random bench for multicycle_subtractor, CHUNK 4/1/2/8 at WIDTH 8
// Checks ovf only when SUB_OVF_EN is defined.
module tb_multicycle_subtractor;

  localparam int NDUT = 4;
  localparam int NCH [NDUT] = '{2, 8, 4, 1};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [7:0]      a = '0;
  logic [7:0]      b = '0;
  logic            bin = 1'b0;
  logic [NDUT-1:0] in_ready_v;
  logic [NDUT-1:0] out_valid_v;
  logic [NDUT-1:0] bout_v;
  logic [NDUT-1:0] ovf_v;
  logic [7:0]      d_v [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CHK = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    multicycle_subtractor #(.WIDTH(8), .CHUNK(CHK)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .d         (d_v[g]),
      .bout      (bout_v[g])
`ifdef SUB_OVF_EN
      ,
      .ovf       (ovf_v[g])
`endif
    );
`ifndef SUB_OVF_EN
    assign ovf_v[g] = 1'b0;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (in_ready_v != '1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(in_ready_v), 32'(4'hF));
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                       input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    logic [NDUT-1:0] seen;
    int lat [NDUT];
    int n;
    wait_idle();
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    seen = '0;
    n = 0;
    while (seen != '1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      for (int g = 0; g < NDUT; g++) begin
        if (out_valid_v[g] && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g]  = n;
          chk({tag, "_d"}, 32'(d_v[g]), 32'(ed));
          chk({tag, "_bout"}, 32'(bout_v[g]), 32'(eb));
`ifdef SUB_OVF_EN
          chk({tag, "_ovf"}, 32'(ovf_v[g]), 32'(eo));
`endif
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      if (!seen[g]) lat[g] = -1;
      chk({tag, "_lat"}, 32'(lat[g]), 32'(NCH[g]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic       rbin;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready_v), 32'(0));
    chk("rst_out_valid", 32'(out_valid_v), 32'(0));
    chk("rst_d0", 32'(d_v[0]), 32'(0));
    chk("rst_bout", 32'(bout_v), 32'(0));
    chk("rst_ovf", 32'(ovf_v), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready_v), 32'(4'hF));

    do_op(8'h0F, 8'h09, 1'b0, 8'h06, 1'b0, 1'b0, "v0f_09");
    do_op(8'h0F, 8'h09, 1'b1, 8'h05, 1'b0, 1'b0, "v0f_09_b");
    do_op(8'h1E, 8'h14, 1'b0, 8'h0A, 1'b0, 1'b0, "v1e_14");
    do_op(8'h0F, 8'h0B, 1'b1, 8'h03, 1'b0, 1'b0, "v0f_0b_b");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "v00_01");
    do_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, "v00_ff_b");
    do_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, "vff_00");
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "v80_01");
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "v10_01");

    // Backpressure on the CHUNK=4 instance.
    wait_idle();
    a = 8'h3C; b = 8'h5A; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 8'h00; b = 8'hFF; bin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_valid", 32'(out_valid_v[0]), 32'(1));
    chk("bp_d", 32'(d_v[0]), 32'(8'hE2));
    chk("bp_bout", 32'(bout_v[0]), 32'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid_v[0]), 32'(1));
      chk("bp_hold_d", 32'(d_v[0]), 32'(8'hE2));
      chk("bp_hold_bout", 32'(bout_v[0]), 32'(1));
      chk("bp_in_ready", 32'(in_ready_v[0]), 32'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid_v[0]), 32'(0));
    chk("bp_release_idle", 32'(in_ready_v[0]), 32'(1));

    // Reset one cycle after the handshake.
    wait_idle();
    a = 8'h55; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready_v), 32'(0));
    chk("mid_rst_valid", 32'(out_valid_v), 32'(0));
    chk("mid_rst_d0", 32'(d_v[0]), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", 32'(in_ready_v), 32'(4'hF));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_valid", 32'(out_valid_v), 32'(0));
    end

    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      m    = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      do_op(ra, rb, rbin, m[7:0], m[8], (ra[7] != rb[7]) && (m[7] != ra[7]), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
